// File: rtl/vga_line_prefetch.sv
// Double-buffered scanline prefetcher: fills one bank from the SDRAM read FIFO while the
// other bank drives the VGA colour outputs.
module vga_line_prefetch #(
    parameter int unsigned H_PIXELS = 640,
    parameter int unsigned V_LINES  = 400,
    parameter int unsigned V_TOTAL  = 525
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        RD,
    input  logic [15:0] RD_DATA,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        fetch_busy,
    output logic        underrun
);
    localparam int unsigned DEPTH = 2 * H_PIXELS;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      r_state;
    logic [9:0]  r_prev_y;
    logic [9:0]  r_cnt;
    logic [9:0]  r_wr_addr;
    logic        r_wr_en;
    logic        r_disp_bank;
    logic        r_pend;
    logic        r_shown;
    logic        r_rd;
    logic        r_busy;
    logic        r_under;
    logic [15:0] r_mem [DEPTH];
    logic [15:0] r_pix;
    logic        r_blank;
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic [7:0]  r_blue;

    logic          w_line_chg;
    logic [10:0]   w_y_next;
    logic [10:0]   w_tgt;
    logic          w_tgt_ok;
    logic          w_x_vis;
    logic          w_y_vis;
    logic [9:0]    w_x_idx;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_wr_idx;

    assign w_line_chg = (DrawY != r_prev_y);
    assign w_y_next   = {1'b0, DrawY} + 11'd1;
    assign w_tgt      = (w_y_next == 11'(V_TOTAL)) ? 11'd0 : w_y_next;
    assign w_tgt_ok   = (w_tgt < 11'(V_LINES));
    assign w_x_vis    = (DrawX < 10'(H_PIXELS));
    assign w_y_vis    = (DrawY < 10'(V_LINES));
    assign w_x_idx    = w_x_vis ? DrawX : 10'd0;

    // Bank 1 lives in the upper half of the shared array; the fill bank is always !disp.
    assign w_rd_idx = r_disp_bank ? AW'(H_PIXELS) + AW'(w_x_idx) : AW'(w_x_idx);
    assign w_wr_idx = r_disp_bank ? AW'(r_wr_addr) : AW'(H_PIXELS) + AW'(r_wr_addr);

    always_ff @(posedge Clk) begin
        if (r_wr_en) begin
            r_mem[w_wr_idx] <= RD_DATA;
        end
        r_pix <= r_mem[w_rd_idx];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_prev_y    <= 10'd0;
            r_cnt       <= 10'd0;
            r_wr_addr   <= 10'd0;
            r_wr_en     <= 1'b0;
            r_disp_bank <= 1'b0;
            r_pend      <= 1'b0;
            r_shown     <= 1'b0;
            r_rd        <= 1'b0;
            r_busy      <= 1'b0;
            r_under     <= 1'b0;
        end else begin
            r_prev_y  <= DrawY;
            // FIFO data for the pop issued this cycle arrives next cycle.
            r_wr_en   <= r_rd;
            r_wr_addr <= r_cnt;
            case (r_state)
                IDLE: begin
                    if (w_line_chg) begin
                        if (r_pend) begin
                            r_disp_bank <= ~r_disp_bank;
                            r_pend      <= 1'b0;
                            r_shown     <= 1'b1;
                        end
                        if (w_tgt_ok) begin
                            r_state <= FETCH;
                            r_cnt   <= 10'd0;
                            r_rd    <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (w_line_chg) begin
                        r_under <= 1'b1;
                    end
                    r_cnt <= r_cnt + 10'd1;
                    if (r_cnt == 10'(H_PIXELS - 1)) begin
                        r_rd    <= 1'b0;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_line_chg) begin
                        r_under <= 1'b1;
                    end
                    r_pend  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Blank flag tracks the memory read so both reach the output register together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_blank <= 1'b1;
            r_red   <= 8'd0;
            r_green <= 8'd0;
            r_blue  <= 8'd0;
        end else begin
            r_blank <= !(w_x_vis && w_y_vis && r_shown);
            if (r_blank) begin
                r_red   <= 8'd0;
                r_green <= 8'd0;
                r_blue  <= 8'd0;
            end else begin
                r_red   <= {r_pix[15:11], r_pix[15:13]};
                r_green <= {r_pix[10:5], r_pix[10:9]};
                r_blue  <= {r_pix[4:0], r_pix[4:2]};
            end
        end
    end

    assign RD         = r_rd;
    assign fetch_busy = r_busy;
    assign underrun   = r_under;
    assign Red        = r_red;
    assign Green      = r_green;
    assign Blue       = r_blue;
endmodule
